monolith_bricks: RTL and testbench

Iterative Bricks layer of the Monolith permutation over the Mersenne-31 field (p = 2^31 − 1). It sits directly downstream of the Bars layer and consumes its reduced 16-word state. It computes y_0 = x_0 and y_i = x_i + x_{i−1}^2 mod p for i ≥ 1, time-multiplexing MUL_COUNT squarers across the state. Ready/valid handshakes on both sides let the round controller stall it.

---
 rtl/monolith_bricks_pkg.sv | 23 ++
 rtl/monolith_bricks_if.sv | 34 +++
 rtl/m31_mod_reduce.sv | 18 +
 rtl/m31_square_reduce.sv | 23 ++
 rtl/monolith_bricks.sv | 112 +++++++++++
 tb/tb_monolith_bricks.sv | 358 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/monolith_bricks_pkg.sv
// monolith_pkg: shared types and constants for the Monolith Bricks layer.
//   WORD_WIDTH  Mersenne-31 element width
//   STATE_SIZE  words per permutation state
//   M31_P       field modulus 2^31 - 1
//   state_t     packed array of STATE_SIZE words
//   fsm_e       Bricks controller states
package monolith_pkg;

  localparam int unsigned WORD_WIDTH = 31;
  localparam int unsigned STATE_SIZE = 16;
  localparam logic [WORD_WIDTH-1:0] M31_P = 31'h7FFF_FFFF;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [STATE_SIZE-1:0] state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  // p and 0 denote the same element; keep only the canonical form.
  function automatic word_t canon(input word_t w);
    return (w == M31_P) ? '0 : w;
  endfunction

endpackage

// File: rtl/monolith_bricks_if.sv
// monolith_bricks_if: input and output ready/valid channels of the Bricks layer.
//   state_in / input_valid / input_ready     upstream (Bars) channel
//   state_out / output_valid / output_ready  downstream (round controller) channel
//   master: the side that feeds states and consumes results
//   slave:  the Bricks block itself
interface monolith_bricks_if;
  import monolith_pkg::*;

  state_t state_in;
  logic   input_valid;
  logic   input_ready;
  state_t state_out;
  logic   output_valid;
  logic   output_ready;

  modport master (
    output state_in,
    output input_valid,
    input  input_ready,
    input  state_out,
    input  output_valid,
    output output_ready
  );

  modport slave (
    input  state_in,
    input  input_valid,
    output input_ready,
    output state_out,
    output output_valid,
    input  output_ready
  );

endinterface

// File: rtl/m31_mod_reduce.sv
// m31_mod_reduce: folds a 32-bit value into a canonical Mersenne-31 element.
//   a  value below 2^32 - 1 (sum of two canonical words or a once-folded square)
//   y  a mod p, in [0, p-1]
module m31_mod_reduce
  import monolith_pkg::*;
(
  input  logic [WORD_WIDTH:0] a,
  output word_t               y
);

  word_t fold;

  // 2^31 == 1 mod p, so the carry bit re-enters at weight 1.
  // For the inputs this block sees the fold never exceeds p.
  assign fold = a[WORD_WIDTH-1:0] + word_t'(a[WORD_WIDTH]);
  assign y    = (fold == M31_P) ? '0 : fold;

endmodule

// File: rtl/m31_square_reduce.sv
// m31_square_reduce: combinational square of a canonical Mersenne-31 element.
//   a  canonical input in [0, p-1]
//   y  a^2 mod p, canonical
module m31_square_reduce
  import monolith_pkg::*;
(
  input  word_t a,
  output word_t y
);

  logic [2*WORD_WIDTH-1:0] sq;
  logic [WORD_WIDTH:0]     fold1;

  assign sq    = {{WORD_WIDTH{1'b0}}, a} * {{WORD_WIDTH{1'b0}}, a};
  // First fold: high half has weight 2^31 == 1.
  assign fold1 = {1'b0, sq[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, sq[WORD_WIDTH-1:0]};

  m31_mod_reduce u_fold (
    .a (fold1),
    .y (y)
  );

endmodule

// File: rtl/monolith_bricks.sv
// monolith_bricks: iterative Bricks layer, y0 = x0, yi = xi + x(i-1)^2 mod p.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of monolith_bricks_if (state in, result out)
// MUL_COUNT squarers sweep the STATE_SIZE-1 lanes in BEATS cycles.
module monolith_bricks
  import monolith_pkg::*;
#(
  parameter int unsigned MUL_COUNT = 4
) (
  input logic              clk,
  input logic              reset,
  monolith_bricks_if.slave bus
);

  localparam int unsigned BEATS  = (STATE_SIZE - 1 + MUL_COUNT - 1) / MUL_COUNT;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W  = $clog2(STATE_SIZE);

  fsm_e              fsm_q, fsm_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  state_t            src_q, src_d;
  state_t            res_q, res_d;

  logic [MUL_COUNT-1:0] lane_ok;
  logic [IDX_W-1:0]     lane_idx [MUL_COUNT];
  word_t                sq_in    [MUL_COUNT];
  word_t                sq_out   [MUL_COUNT];
  word_t                add_in   [MUL_COUNT];
  logic [WORD_WIDTH:0]  sum_raw  [MUL_COUNT];
  word_t                sum      [MUL_COUNT];

  for (genvar m = 0; m < MUL_COUNT; m++) begin : g_lane
    logic [31:0] j;

    assign j           = 32'(beat_q) * MUL_COUNT + m;
    // Slots past the last source lane in the final beat are gated off.
    assign lane_ok[m]  = (j <= 32'(STATE_SIZE - 2));
    assign lane_idx[m] = j[IDX_W-1:0];
    assign sq_in[m]    = lane_ok[m] ? src_q[lane_idx[m]] : '0;
    assign add_in[m]   = lane_ok[m] ? src_q[lane_idx[m] + 1'b1] : '0;

    m31_square_reduce u_sq (
      .a (sq_in[m]),
      .y (sq_out[m])
    );

    assign sum_raw[m] = {1'b0, add_in[m]} + {1'b0, sq_out[m]};

    m31_mod_reduce u_add (
      .a (sum_raw[m]),
      .y (sum[m])
    );
  end

  always_comb begin
    fsm_d  = fsm_q;
    beat_d = beat_q;
    src_d  = src_q;
    res_d  = res_q;
    case (fsm_q)
      IDLE: begin
        if (bus.input_valid) begin
          for (int i = 0; i < STATE_SIZE; i++) begin
            src_d[i] = canon(bus.state_in[i]);
          end
          res_d  = src_d;
          beat_d = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        // Squares read src only, so lane order within the sweep is irrelevant.
        for (int m = 0; m < MUL_COUNT; m++) begin
          if (lane_ok[m]) begin
            res_d[lane_idx[m] + 1'b1] = sum[m];
          end
        end
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          fsm_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.output_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q  <= IDLE;
      beat_q <= '0;
      src_q  <= '0;
      res_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      beat_q <= beat_d;
      src_q  <= src_d;
      res_q  <= res_d;
    end
  end

  assign bus.input_ready  = (fsm_q == IDLE);
  assign bus.output_valid = (fsm_q == DONE);
  assign bus.state_out    = res_q;

endmodule

// File: tb/tb_monolith_bricks.sv
// Bench for monolith_bricks: three instances (MUL_COUNT = 1, 4, 15) share one
// stimulus stream; each instance's latency and results are checked.
module tb_monolith_bricks;
  import monolith_pkg::*;

  logic   clk;
  logic   reset;
  state_t st;
  logic   iv;
  logic   ordy;

  int n_cmp;
  int n_fail;

  monolith_bricks_if if_m1 ();
  monolith_bricks_if if_m4 ();
  monolith_bricks_if if_m15 ();

  assign if_m1.state_in      = st;
  assign if_m1.input_valid   = iv;
  assign if_m1.output_ready  = ordy;
  assign if_m4.state_in      = st;
  assign if_m4.input_valid   = iv;
  assign if_m4.output_ready  = ordy;
  assign if_m15.state_in     = st;
  assign if_m15.input_valid  = iv;
  assign if_m15.output_ready = ordy;

  monolith_bricks #(.MUL_COUNT(1)) u_dut_m1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m1)
  );

  monolith_bricks #(.MUL_COUNT(4)) u_dut_m4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m4)
  );

  monolith_bricks #(.MUL_COUNT(15)) u_dut_m15 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m15)
  );

  logic [2:0] ov;
  logic [2:0] ir;
  state_t     so [3];

  assign ov[0] = if_m1.output_valid;
  assign ov[1] = if_m4.output_valid;
  assign ov[2] = if_m15.output_valid;
  assign ir[0] = if_m1.input_ready;
  assign ir[1] = if_m4.input_ready;
  assign ir[2] = if_m15.input_ready;
  assign so[0] = if_m1.state_out;
  assign so[1] = if_m4.state_out;
  assign so[2] = if_m15.state_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BEATS for instance d (MUL_COUNT 1, 4, 15).
  function automatic int beats_of(input int d);
    case (d)
      0:       return 15;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Present x for one cycle; returns #1 after the capture edge (edge 1).
  task automatic start_op(input state_t x);
    @(posedge clk);
    #1;
    st = x;
    iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
  endtask

  // Advance from edge 1 to #1 after edge 17: every instance is in DONE.
  task automatic wait_all_done();
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic finish_op();
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_input_ready dut%0d: got %b expected 1", d, ir[d]);
      end
      n_cmp++;
      if (ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_output_valid dut%0d: got %b expected 0", d, ov[d]);
      end
      n_cmp++;
      if (so[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_state_out dut%0d: got %h expected 0", d, so[d]);
      end
    end
    reset = 1'b0;
  endtask

  // All-zero state; also checks the cycle output_valid first rises.
  task automatic test_zero();
    state_t x;
    x = '0;
    start_op(x);
    for (int k = 1; k <= 17; k++) begin
      for (int d = 0; d < 3; d++) begin
        logic exp_v;
        exp_v = (k >= beats_of(d) + 1);
        n_cmp++;
        if (ov[d] !== exp_v) begin
          n_fail++;
          $display("FAIL latency dut%0d edge %0d: output_valid got %b expected %b",
                   d, k, ov[d], exp_v);
        end
      end
      if (k < 17) begin
        @(posedge clk);
        #1;
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (so[d] !== '0) begin
        n_fail++;
        $display("FAIL zero dut%0d: got %h expected 0", d, so[d]);
      end
    end
    finish_op();
  endtask

  task automatic test_ramp();
    state_t x;
    state_t e;
    for (int i = 0; i < 16; i++) begin
      x[i] = 31'(i + 1);
      e[i] = (i == 0) ? 31'd1 : 31'(i + 1 + i * i);
    end
    start_op(x);
    wait_all_done();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (so[d][i] !== e[i]) begin
          n_fail++;
          $display("FAIL ramp dut%0d y[%0d]: got %h expected %h", d, i, so[d][i], e[i]);
        end
      end
    end
    finish_op();
  endtask

  task automatic test_minus_one();
    state_t x;
    state_t e;
    x    = '0;
    x[0] = M31_P - 31'd1;
    x[1] = M31_P - 31'd1;
    e    = '0;
    e[0] = M31_P - 31'd1;
    e[1] = 31'd0;
    e[2] = 31'd1;
    start_op(x);
    wait_all_done();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (so[d][i] !== e[i]) begin
          n_fail++;
          $display("FAIL minus_one dut%0d y[%0d]: got %h expected %h", d, i, so[d][i], e[i]);
        end
      end
    end
    finish_op();
  endtask

  task automatic test_fold_and_canon();
    state_t x;
    state_t e;
    x    = '0;
    x[0] = 31'h0001_0000;
    x[1] = 31'd5;
    x[2] = 31'h7FFF_FFFF;
    x[3] = 31'd9;
    e    = '0;
    e[0] = 31'h0001_0000;
    e[1] = 31'd7;
    e[2] = 31'd25;
    e[3] = 31'd9;
    e[4] = 31'd81;
    start_op(x);
    wait_all_done();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (so[d][i] !== e[i]) begin
          n_fail++;
          $display("FAIL fold_canon dut%0d y[%0d]: got %h expected %h", d, i, so[d][i], e[i]);
        end
      end
    end
    finish_op();
  endtask

  // x_i = p-1-i, so x_(i-1)^2 = i^2 and y_i = i^2 - i - 1 for i >= 2.
  task automatic test_large();
    state_t x;
    state_t e;
    for (int i = 0; i < 16; i++) begin
      x[i] = M31_P - 31'd1 - 31'(i);
      e[i] = (i < 2) ? M31_P - 31'd1 : 31'(i * i - i - 1);
    end
    start_op(x);
    wait_all_done();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (so[d][i] !== e[i]) begin
          n_fail++;
          $display("FAIL large dut%0d y[%0d]: got %h expected %h", d, i, so[d][i], e[i]);
        end
      end
    end
    finish_op();
  endtask

  // Results held under back-pressure; a stray input must not be taken.
  task automatic test_stall();
    state_t x;
    state_t e;
    state_t stray;
    for (int i = 0; i < 16; i++) begin
      x[i]     = 31'(i + 1);
      e[i]     = (i == 0) ? 31'd1 : 31'(i + 1 + i * i);
      stray[i] = 31'h123;
    end
    start_op(x);
    wait_all_done();
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        st = stray;
        iv = 1'b1;
      end
      if (c == 4) iv = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (ir[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_input_ready dut%0d cycle %0d: got %b expected 0", d, c, ir[d]);
        end
        n_cmp++;
        if (ov[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_output_valid dut%0d cycle %0d: got %b expected 1", d, c, ov[d]);
        end
        n_cmp++;
        if (so[d] !== e) begin
          n_fail++;
          $display("FAIL stall_state_out dut%0d cycle %0d: got %h expected %h", d, c, so[d], e);
        end
      end
    end
    finish_op();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_release dut%0d: ready/valid got %b%b expected 10", d, ir[d], ov[d]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    state_t x;
    state_t e;
    for (int i = 0; i < 16; i++) x[i] = 31'(i + 1);
    start_op(x);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL midreset_handshake dut%0d: valid/ready got %b%b expected 01",
                 d, ov[d], ir[d]);
      end
      n_cmp++;
      if (so[d] !== '0) begin
        n_fail++;
        $display("FAIL midreset_state_out dut%0d: got %h expected 0", d, so[d]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    x    = '0;
    x[0] = M31_P - 31'd1;
    x[1] = M31_P - 31'd1;
    e    = '0;
    e[0] = M31_P - 31'd1;
    e[2] = 31'd1;
    start_op(x);
    wait_all_done();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (so[d][i] !== e[i]) begin
          n_fail++;
          $display("FAIL after_reset dut%0d y[%0d]: got %h expected %h", d, i, so[d][i], e[i]);
        end
      end
    end
    finish_op();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    st     = '0;
    iv     = 1'b0;
    ordy   = 1'b0;
    test_reset();
    test_zero();
    test_ramp();
    test_minus_one();
    test_fold_and_canon();
    test_stall();
    test_large();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
